// File: rtl/neurosa_host_loader.sv
// neurosa_host_loader: host-side sequencer for the top_neurons 16-bit word bus.
// Optional readout word-count check is enabled by defining NEUROSA_HOST_RDCHK_EN.
module neurosa_host_loader #(
   parameter int FP_DATA_WIDTH    = 16,
   parameter int NEURON_ID_WIDTH  = 8,
   parameter int WORDS_PER_NEURON = 4,
   parameter int RUN_CNT_WIDTH    = 24,
   parameter int FIFO_DEPTH       = 16
) (
   input  logic                       clk,
   input  logic                       reset_l,
   input  logic                       start,
   input  logic [NEURON_ID_WIDTH-1:0] num_active,
   input  logic [RUN_CNT_WIDTH-1:0]   run_cycles,
   input  logic [7:0]                 num_samples,
   input  logic [FP_DATA_WIDTH-1:0]   cfg_data,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   output logic                       chip_reset_l,
   output logic [FP_DATA_WIDTH-1:0]   ins,
   output logic                       rd,
   input  logic [FP_DATA_WIDTH-1:0]   outs,
   input  logic                       readDone,
   output logic [FP_DATA_WIDTH-1:0]   res_data,
   output logic                       res_last,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic                       busy,
   output logic                       err
);

   localparam int LW = NEURON_ID_WIDTH + 3;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_CRST  = 4'd1;
   localparam logic [3:0] S_CNT   = 4'd2;
   localparam logic [3:0] S_BEGIN = 4'd3;
   localparam logic [3:0] S_LOAD  = 4'd4;
   localparam logic [3:0] S_RUN   = 4'd5;
   localparam logic [3:0] S_READ  = 4'd6;
   localparam logic [3:0] S_DRAIN = 4'd7;
   localparam logic [3:0] S_DONE  = 4'd8;
   localparam logic [3:0] S_ERROR = 4'd9;

   logic [3:0]                 state;
   logic                       crst_cnt;
   logic [LW-1:0]              load_cnt;
   logic [LW-1:0]              load_total;
   logic [RUN_CNT_WIDTH-1:0]   run_cnt;
   logic [RUN_CNT_WIDTH-1:0]   rc_q;
   logic [NEURON_ID_WIDTH-1:0] na_q;
   logic [7:0]                 ns_q;
   logic [7:0]                 samp_cnt;
   logic [CW-1:0]              cap_cnt;
   logic                       cap_en;
   logic                       run_done;
   logic                       last_sample;
   logic                       rdchk_bad;
   logic                       fifo_empty;
   logic                       push;
   logic                       pop;
   logic [FP_DATA_WIDTH:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]              wr_ptr;
   logic [AW-1:0]              rd_ptr;
   logic [CW-1:0]              count;

   assign load_total  = LW'(na_q) * LW'(WORDS_PER_NEURON);
   assign run_done    = (rc_q == '0) || (run_cnt == rc_q - RUN_CNT_WIDTH'(1));
   assign last_sample = (samp_cnt + 8'd1) >= ns_q;
   assign fifo_empty  = (count == '0);

`ifdef NEUROSA_HOST_RDCHK_EN
   logic [CW-1:0] exp_words;
   assign exp_words = CW'(na_q >> 4) + CW'(1);
   assign rdchk_bad = (cap_cnt + CW'(1)) != exp_words;
`else
   assign rdchk_bad = 1'b0;
`endif

   // Combinational so the chip leaves reset in the first IDLE cycle after reset_l rises.
   assign chip_reset_l = reset_l && (state != S_CRST);
   assign cfg_ready    = (state == S_LOAD);
   assign busy         = (state != S_IDLE) && (state != S_DONE);
   assign push         = (state == S_READ) && cap_en;
   assign pop          = res_valid && res_ready;

   always_ff @(posedge clk) begin
      if (!reset_l) begin
         state    <= S_IDLE;
         crst_cnt <= 1'b0;
         ins      <= '0;
         rd       <= 1'b0;
         err      <= 1'b0;
         load_cnt <= '0;
         run_cnt  <= '0;
         samp_cnt <= '0;
         cap_cnt  <= '0;
         cap_en   <= 1'b0;
         na_q     <= '0;
         rc_q     <= '0;
         ns_q     <= '0;
      end else begin
         ins <= '0;
         case (state)
            S_IDLE: if (start) begin
               na_q     <= num_active;
               rc_q     <= run_cycles;
               ns_q     <= num_samples;
               samp_cnt <= '0;
               crst_cnt <= 1'b0;
               state    <= S_CRST;
            end
            S_CRST: begin
               crst_cnt <= 1'b1;
               if (crst_cnt) state <= S_CNT;
            end
            S_CNT: begin
               ins   <= FP_DATA_WIDTH'(na_q);
               state <= S_BEGIN;
            end
            S_BEGIN: begin
               ins      <= '1;
               load_cnt <= '0;
               run_cnt  <= '0;
               state    <= (na_q == '0) ? S_RUN : S_LOAD;
            end
            S_LOAD: if (!cfg_valid) begin
               err   <= 1'b1;
               state <= S_ERROR;
            end else begin
               ins      <= cfg_data;
               load_cnt <= load_cnt + LW'(1);
               if (load_cnt == load_total - LW'(1)) begin
                  run_cnt <= '0;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               run_cnt <= run_cnt + RUN_CNT_WIDTH'(1);
               if (run_done) begin
                  if (fifo_empty) begin
                     rd      <= 1'b1;
                     cap_en  <= 1'b0;
                     cap_cnt <= '0;
                     state   <= S_READ;
                  end else begin
                     state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: if (fifo_empty) begin
               rd      <= 1'b1;
               cap_en  <= 1'b0;
               cap_cnt <= '0;
               state   <= S_READ;
            end
            S_READ: begin
               // The chip answers one cycle after it sees rd, so capture starts on the second READ cycle.
               cap_en <= 1'b1;
               if (cap_en) begin
                  cap_cnt <= cap_cnt + CW'(1);
                  if (readDone) begin
                     rd       <= 1'b0;
                     cap_en   <= 1'b0;
                     samp_cnt <= samp_cnt + 8'd1;
                     run_cnt  <= '0;
                     if (rdchk_bad) begin
                        err   <= 1'b1;
                        state <= S_ERROR;
                     end else begin
                        state <= last_sample ? S_DONE : S_RUN;
                     end
                  end else if (cap_cnt == CW'(FIFO_DEPTH - 1)) begin
                     rd    <= 1'b0;
                     err   <= 1'b1;
                     state <= S_ERROR;
                  end
               end
            end
            S_DONE: if (start) begin
               rc_q     <= run_cycles;
               ns_q     <= num_samples;
               samp_cnt <= '0;
               run_cnt  <= '0;
               state    <= S_RUN;
            end
            S_ERROR: rd <= 1'b0;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {readDone, outs};
   end

   always_ff @(posedge clk) begin
      if (!reset_l) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   assign res_valid = !fifo_empty;
   assign res_data  = res_valid ? mem[rd_ptr][FP_DATA_WIDTH-1:0] : '0;
   assign res_last  = res_valid && mem[rd_ptr][FP_DATA_WIDTH];

endmodule

// File: tb/tb_neurosa_host_loader.sv
// Directed bench for neurosa_host_loader with a simple top_neurons readout model.
// Expectations follow NEUROSA_HOST_RDCHK_EN when it is defined for the build.
module tb_neurosa_host_loader;

   logic        clk = 1'b0;
   logic        reset_l = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  num_active = '0;
   logic [23:0] run_cycles = '0;
   logic [7:0]  num_samples = '0;
   logic [15:0] cfg_data;
   logic        cfg_valid;
   logic        cfg_ready;
   logic        chip_reset_l;
   logic [15:0] ins;
   logic        rd;
   logic [15:0] outs = '0;
   logic        readDone = 1'b0;
   logic [15:0] res_data;
   logic        res_last;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic        busy;
   logic        err;

   int checks = 0;
   int errors = 0;

   // Config feeder and chip readout model
   int          cfg_idx = 0;
   int          drop_at = -1;
   logic        feed_en = 1'b1;
   logic        feed_clr = 1'b1;
   int          chip_len = 1;
   logic [15:0] chip_base = '0;
   int          ck = 0;
   int          ro_idx = 0;
   logic        ro_clr = 1'b1;

   int          n;
   logic        seen;
   logic [16:0] q[$];

   always #5 clk = ~clk;

   neurosa_host_loader #(
      .FP_DATA_WIDTH(16),
      .NEURON_ID_WIDTH(8),
      .WORDS_PER_NEURON(4),
      .RUN_CNT_WIDTH(24),
      .FIFO_DEPTH(16)
   ) dut (
      .clk(clk), .reset_l(reset_l), .start(start), .num_active(num_active),
      .run_cycles(run_cycles), .num_samples(num_samples), .cfg_data(cfg_data),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .chip_reset_l(chip_reset_l),
      .ins(ins), .rd(rd), .outs(outs), .readDone(readDone), .res_data(res_data),
      .res_last(res_last), .res_valid(res_valid), .res_ready(res_ready),
      .busy(busy), .err(err)
   );

   assign cfg_valid = feed_en && (cfg_idx != drop_at);
   assign cfg_data  = 16'(32'h1000 + cfg_idx);

   always @(posedge clk) begin
      if (feed_clr) cfg_idx <= 0;
      else if (cfg_ready && cfg_valid) cfg_idx <= cfg_idx + 1;
   end

   always @(posedge clk) begin
      if (rd) begin
         outs     <= chip_base + 16'(ro_idx * 256) + 16'(ck);
         readDone <= (ck == chip_len - 1);
         ck       <= ck + 1;
      end else begin
         outs     <= '0;
         readDone <= 1'b0;
         ck       <= 0;
      end
      if (ro_clr) ro_idx <= 0;
      else if (rd && readDone) ro_idx <= ro_idx + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_l = 1'b0;
      ro_clr = 1'b1;
      feed_clr = 1'b1;
      step();
      step();
      reset_l = 1'b1;
      ro_clr = 1'b0;
      feed_clr = 1'b0;
      step();
   endtask

   task automatic pulse_start(input logic [7:0] na, input logic [23:0] rc, input logic [7:0] ns);
      num_active = na;
      run_cycles = rc;
      num_samples = ns;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      reset_l = 1'b0;
      step();
      step();
      chk("rst_chip_reset_l", chip_reset_l, 0);
      chk("rst_ins", ins, 0);
      chk("rst_rd", rd, 0);
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_last", res_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      reset_l = 1'b1;
      ro_clr = 1'b0;
      feed_clr = 1'b0;
      step();
      chk("idle_chip_reset_l", chip_reset_l, 1);

      // A: 8 neurons, 32 config words, run 10, one sample
      chip_len = 1;
      chip_base = 16'h5A00;
      res_ready = 1'b1;
      pulse_start(8'd8, 24'd10, 8'd1);
      n = 0;
      while (!chip_reset_l && n < 10) begin step(); n++; end
      chk("A_crst_cycles", n, 2);
      n = 0;
      while (ins !== 16'h0008 && n < 10) begin step(); n++; end
      chk("A_ins_count", ins, 16'h0008);
      for (int i = 0; i < 33; i++) begin
         step();
         chk($sformatf("A_ins_word%0d", i), ins, (i == 0) ? 16'hFFFF : 16'(32'h1000 + i - 1));
      end
      n = 0;
      while (!rd && n < 100) begin step(); n++; end
      chk("A_rd_low_cycles", n, 10);
      n = 0;
      while (!res_valid && n < 20) begin step(); n++; end
      chk("A_res_valid", res_valid, 1);
      chk("A_res_data", res_data, 16'h5A00);
      chk("A_res_last", res_last, 1);
      chk("A_rd_dropped", rd, 0);
      chk("A_done_busy", busy, 0);
      chk("A_err", err, 0);
      chk("A_cfg_consumed", cfg_idx, 32);
      step();
      chk("A_popped", res_valid, 0);

      // B: 64 neurons -> five readout words, rd drops on the edge after readDone
      do_reset();
      chip_len = 5;
      chip_base = 16'h7700;
      res_ready = 1'b0;
      pulse_start(8'd64, 24'd3, 8'd1);
      n = 0;
      while (!rd && n < 600) begin step(); n++; end
      chk("B_rd_rise", rd, 1);
      n = 0;
      while (!readDone && n < 20) begin step(); n++; end
      chk("B_readDone_seen", readDone, 1);
      chk("B_rd_at_readDone", rd, 1);
      step();
      chk("B_rd_after_readDone", rd, 0);
      chk("B_done_busy", busy, 0);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("B_valid%0d", k), res_valid, 1);
         chk($sformatf("B_data%0d", k), res_data, 16'(32'h7700 + k));
         chk($sformatf("B_last%0d", k), res_last, (k == 4) ? 1 : 0);
         res_ready = 1'b1;
         step();
         res_ready = 1'b0;
      end
      chk("B_fifo_empty", res_valid, 0);

      // C: new batch from DONE, three samples, consumer stalled so DRAIN holds rd low
      chip_base = 16'hA000;
      ro_clr = 1'b1;
      step();
      ro_clr = 1'b0;
      pulse_start(8'd0, 24'd4, 8'd3);
      n = 0;
      while (!readDone && n < 40) begin step(); n++; end
      chk("C_first_readDone", readDone, 1);
      step();
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         seen = seen | rd;
         step();
      end
      chk("C_drain_rd_low", seen, 0);
      chk("C_drain_busy", busy, 1);
      res_ready = 1'b1;
      q.delete();
      n = 0;
      while (n < 400) begin
         if (res_valid) q.push_back({res_last, res_data});
         if (!busy && !res_valid) break;
         step();
         n++;
      end
      chk("C_word_count", q.size(), 15);
      for (int i = 0; i < q.size() && i < 15; i++) begin
         chk($sformatf("C_word%0d", i), q[i], {(i % 5 == 4), 16'(32'hA000 + (i / 5) * 256 + (i % 5))});
      end
      chk("C_no_reload", cfg_idx, 256);
      chk("C_err", err, 0);

      // D: cfg_valid missing on load word 7
      do_reset();
      drop_at = 7;
      res_ready = 1'b1;
      pulse_start(8'd8, 24'd5, 8'd1);
      n = 0;
      while (!err && n < 60) begin step(); n++; end
      chk("D_err", err, 1);
      chk("D_words_consumed", cfg_idx, 7);
      chk("D_ins_zero", ins, 0);
      chk("D_cfg_ready", cfg_ready, 0);
      for (int i = 0; i < 5; i++) step();
      chk("D_ins_later", ins, 0);
      chk("D_rd_later", rd, 0);
      chk("D_err_sticky", err, 1);
      chk("D_busy", busy, 1);
      drop_at = -1;

      // E: chip never raises readDone -> 16 words then error
      do_reset();
      chip_len = 1000;
      chip_base = 16'h3000;
      res_ready = 1'b0;
      pulse_start(8'd8, 24'd1, 8'd1);
      n = 0;
      while (!err && n < 300) begin step(); n++; end
      chk("E_err", err, 1);
      chk("E_rd", rd, 0);
      n = 0;
      seen = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (res_valid) begin
            n++;
            seen = seen | res_last;
         end
         step();
      end
      chk("E_word_count", n, 16);
      chk("E_no_last", seen, 0);

      // G: 64 neurons but chip returns 3 words; run_cycles=0 and num_samples=0 act as 1
      do_reset();
      chip_len = 3;
      chip_base = 16'h4400;
      res_ready = 1'b1;
      pulse_start(8'd64, 24'd0, 8'd0);
      q.delete();
      n = 0;
      while (n < 800) begin
         if (res_valid) q.push_back({res_last, res_data});
         if ((!busy || err) && !res_valid) break;
         step();
         n++;
      end
      chk("G_word_count", q.size(), 3);
      if (q.size() == 3) chk("G_last_word", q[2], {1'b1, 16'h4402});
`ifdef NEUROSA_HOST_RDCHK_EN
      chk("G_err", err, 1);
`else
      chk("G_err", err, 0);
      chk("G_done", busy, 0);
`endif

      // F: reset during READ
      do_reset();
      chip_len = 5;
      chip_base = 16'h6600;
      res_ready = 1'b0;
      pulse_start(8'd8, 24'd2, 8'd1);
      n = 0;
      while (!rd && n < 100) begin step(); n++; end
      chk("F_rd_rise", rd, 1);
      step();
      step();
      step();
      chk("F_pre_reset_valid", res_valid, 1);
      reset_l = 1'b0;
      step();
      chk("F_chip_reset_l", chip_reset_l, 0);
      chk("F_ins", ins, 0);
      chk("F_rd", rd, 0);
      chk("F_cfg_ready", cfg_ready, 0);
      chk("F_res_valid", res_valid, 0);
      chk("F_res_last", res_last, 0);
      chk("F_busy", busy, 0);
      chk("F_err", err, 0);
      reset_l = 1'b1;
      step();
      chk("F_idle_chip_reset_l", chip_reset_l, 1);
      chk("F_idle_busy", busy, 0);
      chk("F_idle_fifo", res_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
